// File: rtl/jtag_host_ctrl.sv
// jtag_host_ctrl: JTAG host driving TMS/TDI in lockstep with the slave TAP; JTAG_HOST_IDLE_EN adds post-scan RTI cycles.
// Latency: o_rspValid rises REG_W+5 TCK edges after the accepting edge for DR scans, REG_W+6 for IR scans.
// Backpressure: response held stable in Run-Test/Idle until i_rspReady; commands accepted only while idle.
module jtag_host_ctrl #(
    parameter int REG_W       = 8,
    parameter int IDLE_CYCLES = 4
) (
    input  logic             i_tclk,
    input  logic             i_trst_n,
    input  logic             i_cmdValid,
    output logic             o_cmdReady,
    input  logic             i_cmdIsIr,
    input  logic [REG_W-1:0] i_cmdData,
    output logic             o_rspValid,
    input  logic             i_rspReady,
    output logic [REG_W-1:0] o_rspData,
    output logic             o_tms,
    output logic             o_tdi,
    input  logic             i_tdo,
    output logic             o_busy
);

    // One counter serves the reset walk (0..5), the shift index and the idle wait.
    localparam int SHIFT_CW = $clog2(REG_W) + 1;
    localparam int IDLE_CW  = $clog2(IDLE_CYCLES + 1);
    localparam int CNT_A    = (SHIFT_CW > 3) ? SHIFT_CW : 3;
    localparam int CNT_W    = (IDLE_CW > CNT_A) ? IDLE_CW : CNT_A;
    localparam int IDX_W    = (REG_W > 1) ? $clog2(REG_W) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(5);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(REG_W - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        ST_RESET,
        ST_IDLE,
        ST_LAUNCH,
        ST_SEL_DR,
        ST_SEL_IR,
        ST_CAPTURE,
        ST_SHIFT,
        ST_EXIT1,
        ST_UPDATE,
        ST_RSP,
        ST_IDLE_WAIT
    } state_t;

    state_t             state, stateNxt;
    logic [CNT_W-1:0]   cnt, cntNxt;
    logic [REG_W-1:0]   cmdReg, cmdRegNxt;
    logic               cmdIr, cmdIrNxt;
    logic [REG_W-1:0]   rspReg, rspNxt;
    logic               tmsDec, tdiDec;

    always_ff @(posedge i_tclk) begin
        if (!i_trst_n) begin
            state  <= ST_RESET;
            cnt    <= '0;
            cmdReg <= '0;
            cmdIr  <= 1'b0;
            rspReg <= '0;
        end else begin
            state  <= stateNxt;
            cnt    <= cntNxt;
            cmdReg <= cmdRegNxt;
            cmdIr  <= cmdIrNxt;
            rspReg <= rspNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        cntNxt    = cnt;
        cmdRegNxt = cmdReg;
        cmdIrNxt  = cmdIr;
        rspNxt    = rspReg;
        tmsDec    = 1'b0;
        tdiDec    = 1'b0;
        case (state)
            ST_RESET: begin
                // Five TMS=1 edges force Test-Logic-Reset from any TAP state, then one 0 into RTI.
                tmsDec = (cnt < RESET_LAST);
                if (cnt == RESET_LAST) begin
                    stateNxt = ST_IDLE;
                    cntNxt   = '0;
                end else begin
                    cntNxt = cnt + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (i_cmdValid) begin
                    cmdRegNxt = i_cmdData;
                    cmdIrNxt  = i_cmdIsIr;
                    stateNxt  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tmsDec   = 1'b1;
                stateNxt = ST_SEL_DR;
            end
            ST_SEL_DR: begin
                tmsDec   = cmdIr;
                stateNxt = cmdIr ? ST_SEL_IR : ST_CAPTURE;
            end
            ST_SEL_IR: stateNxt = ST_CAPTURE;
            ST_CAPTURE: begin
                cntNxt   = '0;
                stateNxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                tdiDec = cmdReg[cnt[IDX_W-1:0]];
                tmsDec = (cnt == SHIFT_LAST);
                rspNxt = {i_tdo, rspReg[REG_W-1:1]};
                if (cnt == SHIFT_LAST) begin
                    stateNxt = ST_EXIT1;
                end else begin
                    cntNxt = cnt + CNT_ONE;
                end
            end
            ST_EXIT1: begin
                tmsDec   = 1'b1;
                stateNxt = ST_UPDATE;
            end
            ST_UPDATE: stateNxt = ST_RSP;
            ST_RSP: begin
                if (i_rspReady) begin
`ifdef JTAG_HOST_IDLE_EN
                    cntNxt   = '0;
                    stateNxt = (IDLE_CYCLES == 0) ? ST_IDLE : ST_IDLE_WAIT;
`else
                    stateNxt = ST_IDLE;
`endif
                end
            end
            ST_IDLE_WAIT: begin
                if (cnt == IDLE_LAST) begin
                    cntNxt   = '0;
                    stateNxt = ST_IDLE;
                end else begin
                    cntNxt = cnt + CNT_ONE;
                end
            end
            default: stateNxt = ST_RESET;
        endcase
    end

    assign o_tms      = tmsDec;
    assign o_tdi      = tdiDec;
    assign o_cmdReady = (state == ST_IDLE);
    assign o_busy     = (state != ST_IDLE);
    assign o_rspValid = (state == ST_RSP);
    assign o_rspData  = rspReg;

endmodule

// File: tb/tb_jtag_host_ctrl.sv
// Bench for jtag_host_ctrl: host wired to a behavioural 16-state TAP slave with 8-bit IR and DR.
module tb_jtag_host_ctrl;

    localparam int REG_W       = 8;
    localparam int IDLE_CYCLES = 4;
`ifdef JTAG_HOST_IDLE_EN
    localparam int EXP_IDLE = IDLE_CYCLES;
`else
    localparam int EXP_IDLE = 0;
`endif

    logic             tclk     = 1'b0;
    logic             trstN    = 1'b0;
    logic             cmdValid = 1'b0;
    logic             cmdReady;
    logic             cmdIsIr  = 1'b0;
    logic [REG_W-1:0] cmdData  = '0;
    logic             rspValid;
    logic             rspReady = 1'b0;
    logic [REG_W-1:0] rspData;
    logic             tms, tdi, tdo, busy;

    always #5 tclk = ~tclk;

    jtag_host_ctrl #(.REG_W(REG_W), .IDLE_CYCLES(IDLE_CYCLES)) dut (
        .i_tclk(tclk), .i_trst_n(trstN),
        .i_cmdValid(cmdValid), .o_cmdReady(cmdReady),
        .i_cmdIsIr(cmdIsIr), .i_cmdData(cmdData),
        .o_rspValid(rspValid), .i_rspReady(rspReady), .o_rspData(rspData),
        .o_tms(tms), .o_tdi(tdi), .i_tdo(tdo), .o_busy(busy)
    );

    // Reference slave: IEEE 1149.1 TAP graph, capture/shift/update of 8-bit IR and DR.
    typedef enum int {TLR, RTI, SDS, CDR, SDR, E1D, PD, E2D, UDR,
                      SIS, CIR, SIR, E1I, PI, E2I, UIR} tap_t;
    tap_t       tap   = TLR;
    logic [7:0] sr    = '0;
    logic [7:0] irCap = '0, drCap = '0, irUpd = '0, drUpd = '0;
    assign tdo = sr[0];

    function automatic tap_t tapNext(input tap_t s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDS : RTI;
            SDS: return m ? SIS : CDR;
            CDR: return m ? E1D : SDR;
            SDR: return m ? E1D : SDR;
            E1D: return m ? UDR : PD;
            PD:  return m ? E2D : PD;
            E2D: return m ? UDR : SDR;
            UDR: return m ? SDS : RTI;
            SIS: return m ? TLR : CIR;
            CIR: return m ? E1I : SIR;
            SIR: return m ? E1I : SIR;
            E1I: return m ? UIR : PI;
            PI:  return m ? E2I : PI;
            E2I: return m ? UIR : SIR;
            UIR: return m ? SDS : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tclk) begin
        if (!trstN) begin
            tap <= TLR;
        end else begin
            tap <= tapNext(tap, tms);
            case (tap)
                CIR:      sr <= irCap;
                CDR:      sr <= drCap;
                SIR, SDR: sr <= {tdi, sr[7:1]};
                UIR:      irUpd <= sr;
                UDR:      drUpd <= sr;
                default: ;
            endcase
        end
    end

    int nCmp  = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Entered at the negedge of the first cycle after reset release (state RESET, count 0).
    task automatic resetSeq(input string tag);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_tms%0d", tag, i), 32'(tms), (i < 5) ? 32'd1 : 32'd0);
            check($sformatf("%s_rdyLow%0d", tag, i), 32'(cmdReady), 32'd0);
            @(negedge tclk);
        end
        check({tag, "_cmdReady"}, 32'(cmdReady), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rspValid"}, 32'(rspValid), 32'd0);
        check({tag, "_tapRti"}, 32'(tap), 32'(RTI));
    endtask

    task automatic runScan(input string tag, input logic isIr, input logic [7:0] data,
                           input logic [7:0] cap, input logic [7:0] expRsp, input int expLat,
                           input int rspDelay, input bit junk, input bit early);
        bit         tmsExp[$];
        int         k, w, pos, shiftStart;
        logic       expTdi, seenReady;
        logic [7:0] otherPrev;
        w = 0;
        while (!cmdReady && w < 50) begin
            @(negedge tclk);
            w++;
        end
        check({tag, "_readyBeforeCmd"}, 32'(cmdReady), 32'd1);
        if (!cmdReady) return;
        if (isIr) irCap = cap; else drCap = cap;
        otherPrev = isIr ? drUpd : irUpd;
        cmdValid = 1'b1; cmdIsIr = isIr; cmdData = data; rspReady = early;
        @(negedge tclk);
        // Expected TMS from LAUNCH through UPDATE.
        tmsExp.push_back(1'b1);
        tmsExp.push_back(isIr);
        if (isIr) tmsExp.push_back(1'b0);
        tmsExp.push_back(1'b0);
        for (int i = 0; i < REG_W; i++) tmsExp.push_back(i == REG_W - 1);
        tmsExp.push_back(1'b1);
        tmsExp.push_back(1'b0);
        shiftStart = isIr ? 4 : 3;
        seenReady = 1'b0;
        k = 1;
        while (!rspValid && k <= 40) begin
            if (junk) begin
                cmdValid = 1'b1; cmdData = 8'($urandom); cmdIsIr = 1'($urandom);
            end else begin
                cmdValid = 1'b0;
            end
            pos = k - 1;
            if (pos < tmsExp.size())
                check($sformatf("%s_tms%0d", tag, pos), 32'(tms), 32'(tmsExp[pos]));
            expTdi = (pos >= shiftStart && pos < shiftStart + REG_W) ? data[3'(pos - shiftStart)] : 1'b0;
            check($sformatf("%s_tdi%0d", tag, pos), 32'(tdi), 32'(expTdi));
            seenReady = seenReady | cmdReady;
            @(negedge tclk);
            k++;
        end
        cmdValid = 1'b0;
        check({tag, "_latency"}, 32'(k - 1), 32'(expLat));
        check({tag, "_rspData"}, 32'(rspData), 32'(expRsp));
        check({tag, "_slaveUpd"}, isIr ? 32'(irUpd) : 32'(drUpd), 32'(data));
        check({tag, "_otherUpd"}, isIr ? 32'(drUpd) : 32'(irUpd), 32'(otherPrev));
        check({tag, "_tapRti"}, 32'(tap), 32'(RTI));
        check({tag, "_noReadyBusy"}, 32'(seenReady | cmdReady), 32'd0);
        for (int d = 0; d < rspDelay && !early; d++) begin
            @(negedge tclk);
            check($sformatf("%s_stallValid%0d", tag, d), 32'(rspValid), 32'd1);
            check($sformatf("%s_stallData%0d", tag, d), 32'(rspData), 32'(expRsp));
            check($sformatf("%s_stallTms%0d", tag, d), 32'(tms), 32'd0);
            check($sformatf("%s_stallRdy%0d", tag, d), 32'(cmdReady), 32'd0);
        end
        rspReady = 1'b1;
        @(negedge tclk);
        rspReady = 1'b0;
        check({tag, "_rspDone"}, 32'(rspValid), 32'd0);
        w = 0;
        while (!cmdReady && w < 20) begin
            check($sformatf("%s_idleTms%0d", tag, w), 32'(tms), 32'd0);
            check($sformatf("%s_idleBusy%0d", tag, w), 32'(busy), 32'd1);
            @(negedge tclk);
            w++;
        end
        check({tag, "_idleCycles"}, 32'(w), 32'(EXP_IDLE));
        check({tag, "_tapRtiEnd"}, 32'(tap), 32'(RTI));
    endtask

    typedef struct {
        logic       isIr;
        logic [7:0] data;
        logic [7:0] cap;
        logic [7:0] expRsp;
        int         expLat;
        int         rspDelay;
        bit         junk;
        bit         early;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic       rIr;
        logic [7:0] rData, rCap, prevDr;

        vecs[0] = '{1'b1, 8'h5A, 8'h01, 8'h01, REG_W + 6, 0,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hC3, 8'h96, 8'h96, REG_W + 5, 0,  1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'hE7, 8'h5B, 8'h5B, REG_W + 5, 20, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'h00, REG_W + 6, 2,  1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 8'hFF, 8'hFF, REG_W + 5, 0,  1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h80, 8'h81, 8'h81, REG_W + 6, 1,  1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h01, 8'h80, 8'h80, REG_W + 5, 3,  1'b1, 1'b0};

        trstN = 1'b0;
        repeat (3) @(posedge tclk);
        @(negedge tclk);
        check("rst_tms", 32'(tms), 32'd1);
        check("rst_tdi", 32'(tdi), 32'd0);
        check("rst_cmdReady", 32'(cmdReady), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rspValid", 32'(rspValid), 32'd0);
        check("rst_rspData", 32'(rspData), 32'd0);
        trstN = 1'b1;
        resetSeq("rel");

        foreach (vecs[i])
            runScan($sformatf("vec%0d", i), vecs[i].isIr, vecs[i].data, vecs[i].cap,
                    vecs[i].expRsp, vecs[i].expLat, vecs[i].rspDelay, vecs[i].junk, vecs[i].early);

        // Reset during SHIFT with count 3: scan aborted, slave DR never updated.
        prevDr = drUpd;
        drCap = 8'hA5;
        cmdValid = 1'b1; cmdIsIr = 1'b0; cmdData = 8'h3C;
        @(negedge tclk);
        cmdValid = 1'b0;
        repeat (6) @(negedge tclk);
        check("mid_inShift", 32'(tap), 32'(SDR));
        trstN = 1'b0;
        @(negedge tclk);
        check("mid_rspValid", 32'(rspValid), 32'd0);
        check("mid_rspData", 32'(rspData), 32'd0);
        check("mid_tms", 32'(tms), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        trstN = 1'b1;
        resetSeq("mid");
        check("mid_cmdLost", 32'(drUpd), 32'(prevDr));

        // Randomized scans, expectations from the slave model's capture/update rules.
        for (int i = 0; i < 24; i++) begin
            rIr   = 1'($urandom_range(0, 1));
            rData = 8'($urandom);
            rCap  = 8'($urandom);
            runScan($sformatf("rnd%0d", i), rIr, rData, rCap, rCap, REG_W + 5 + int'(rIr),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", nCmp, nFail);
        $fatal(1, "watchdog");
    end

endmodule
